booth_r4_core: RTL
==================

BOOTH_R4_CORE -- requirements
Module: booth_r4_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; even values >= 4 only, any other value is an elaboration error.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH/2+2), width of the iteration counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  core accepts operands.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand M.
REQ-008 SHALL have port multiplier  input  WIDTH  operand Q.
REQ-009 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-010 SHALL have port step_mode  input  1  1 = iterations advance only on step_pulse.
REQ-011 SHALL have port step_pulse  input  1  single-cycle step request for manual stepping.
REQ-012 SHALL have port out_valid  output  1  product available.
REQ-013 SHALL have port out_ready  input  1  consumer takes the product.
REQ-014 SHALL have port product  output  2*WIDTH  exact product.
REQ-015 SHALL have port busy  output  1  high in CALC.
REQ-016 SHALL have port iter_count  output  CNT_W  number of completed iterations.

Function
REQ-017 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-018 SHALL drive in_ready=1 only in IDLE and accept operands on in_valid & in_ready (cycle T), entering CALC with iter_count=0.
REQ-019 SHALL extend operands at capture: M to WIDTH+1 bits, Q to WIDTH+2 bits, sign-extended if is_signed else zero-extended; A (WIDTH+3 bits) and q_m1 cleared.
REQ-020 SHALL perform each iteration as: recode {Q[1:0],q_m1} into {0,+M,+2M,-M,-2M}, add to A, then arithmetic-shift {A,Q,q_m1} right by 2.
REQ-021 SHALL run N = WIDTH/2+1 iterations for both modes; iter_count increments per iteration.
REQ-022 SHALL, with step_mode=0, iterate every CALC cycle: cycles T+1..T+N, out_valid first high at T+N+1.
REQ-023 SHALL, with step_mode=1, iterate only in CALC cycles with step_pulse=1; step_mode is sampled every cycle and may change mid-operation.
REQ-024 SHALL ignore step_pulse outside CALC.
REQ-025 SHALL set product = {A,Q}[2*WIDTH-1:0] on entry to DONE, with out_valid=1; product is exact for all operand values in both modes.
REQ-026 SHALL hold product and out_valid stable in DONE until out_ready=1, then return to IDLE with out_valid=0.
REQ-027 SHALL NOT bypass DONE->accept: in_valid during DONE is accepted at the earliest one cycle after the out handshake.
REQ-028 SHALL hold product at its last value in IDLE and CALC; only the DONE entry and reset update it.

Reset
REQ-029 SHALL, on a clock edge with rst_n=0, enter IDLE from any state (including mid-CALC, discarding the operation) with product=0, out_valid=0, busy=0, iter_count=0, A/Q/q_m1=0.
REQ-030 SHALL drive in_ready=1 from the first cycle after reset release.

Structure
REQ-031 SHALL place the FSM state enum and the recoded-digit encoding (ZERO, PM, P2M, NM, N2M) in shared package booth_pkg.
REQ-032 SHALL use one combinational sub-module booth_r4_recoder (3-bit window -> digit select); the remaining logic is in booth_r4_core.

Verification (WIDTH=8, step_mode=0 unless stated)
REQ-033 SHALL cover unsigned 255 x 255 -> product 0xFE01, out_valid at T+6.
REQ-034 SHALL cover signed -128 x -128 -> 0x4000, and signed -128 x 127 -> 0xC080.
REQ-035 SHALL cover step_mode=1 with 3 step_pulses -> iter_count=3, out_valid=0; 2 further pulses -> product valid next cycle.
REQ-036 SHALL cover out_ready held low 10 cycles in DONE, with in_valid=1 throughout -> product and out_valid stable, in_ready=0, new operands accepted one cycle after out_ready.
REQ-037 SHALL cover rst_n=0 at iter_count=2 -> next cycle IDLE, in_ready=1, out_valid=0, product=0.
REQ-038 SHALL cover a random 10k-operand check in both modes against a reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared FSM state and radix-4 digit encodings for the Booth core
package booth_pkg;

  // Control states of the multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recoded radix-4 Booth digit: selects the addend applied to A
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } digit_t;

endpackage

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - maps a 3-bit {Q[1:0],q_m1} window to a Booth digit
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output digit_t     digit
);

  // Standard radix-4 recoding table: digit = -2*w[2] + w[1] + w[0]
  always_comb begin
    digit = ZERO;
    case (window)
      3'b000:  digit = ZERO;
      3'b001:  digit = PM;
      3'b010:  digit = PM;
      3'b011:  digit = P2M;
      3'b100:  digit = N2M;
      3'b101:  digit = NM;
      3'b110:  digit = NM;
      3'b111:  digit = ZERO;
      default: digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_core.sv
// rtl/booth_r4_core.sv - iterative radix-4 Booth multiplier with manual stepping
module booth_r4_core
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  input  logic                 step_mode,
  input  logic                 step_pulse,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [CNT_W-1:0]     iter_count
);

  // Odd or too-small widths break the 2-bit-per-iteration shift schedule
  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_r4_core: WIDTH must be even and >= 4");
  end

  // One extra iteration consumes the extension bits so unsigned operands come out exact
  localparam int N = WIDTH/2 + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N-1);

  state_t               state, state_nxt;
  logic [WIDTH:0]       m_reg;
  logic [WIDTH+1:0]     q_reg;
  logic [WIDTH+2:0]     a_reg;
  logic                 q_m1;
  logic [CNT_W-1:0]     iter_q;
  logic [2*WIDTH-1:0]   product_q;

  digit_t               digit;
  logic [WIDTH+2:0]     m_x1, m_x2, addend, a_sum, a_next;
  logic [WIDTH+1:0]     q_next;
  logic                 accept, advance, finish;

  booth_r4_recoder u_recoder (
    .window ({q_reg[1:0], q_m1}),
    .digit  (digit)
  );

  // One iteration: add the recoded multiple of M to A, then shift {A,Q,q_m1} right by 2
  always_comb begin
    m_x1   = {{2{m_reg[WIDTH]}}, m_reg};
    m_x2   = {m_reg[WIDTH], m_reg, 1'b0};
    addend = '0;
    case (digit)
      PM:      addend = m_x1;
      P2M:     addend = m_x2;
      NM:      addend = -m_x1;
      N2M:     addend = -m_x2;
      default: addend = '0;
    endcase
    a_sum  = a_reg + addend;
    a_next = {{2{a_sum[WIDTH+2]}}, a_sum[WIDTH+2:2]};
    q_next = {a_sum[1:0], q_reg[WIDTH+1:2]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (!step_mode || step_pulse) begin
          advance = 1'b1;
          if (iter_q == LAST_ITER) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration registers and product latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg     <= '0;
      q_reg     <= '0;
      a_reg     <= '0;
      q_m1      <= 1'b0;
      iter_q    <= '0;
      product_q <= '0;
    end else if (accept) begin
      m_reg  <= {is_signed & multiplicand[WIDTH-1], multiplicand};
      q_reg  <= {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
      a_reg  <= '0;
      q_m1   <= 1'b0;
      iter_q <= '0;
    end else if (advance) begin
      a_reg  <= a_next;
      q_reg  <= q_next;
      q_m1   <= q_reg[1];
      iter_q <= iter_q + CNT_W'(1);
      if (finish) product_q <= {a_next[WIDTH-3:0], q_next};
    end
  end

  assign product    = product_q;
  assign iter_count = iter_q;

endmodule
